// File: rtl/nx_ctrl_serialiser_pkg.sv
// ----------------------------------------------------------------------------
// NXConstants
// Shared widths and packet-format types for the control path and the host
// stream link.
//   CONTROL_RESPONSE_WIDTH : width of one control response
//   HOST_STREAM_WIDTH      : width of one host stream word
//   control_response_t     : one wide control response
//   ser_state_t            : serialiser FSM state encoding
// ----------------------------------------------------------------------------
package NXConstants;

    localparam int CONTROL_RESPONSE_WIDTH = 128;
    localparam int HOST_STREAM_WIDTH      = 32;

    typedef logic [CONTROL_RESPONSE_WIDTH-1:0] control_response_t;

    typedef enum logic {
        SER_EMPTY  = 1'b0,
        SER_STREAM = 1'b1
    } ser_state_t;

endpackage

// File: rtl/nx_ser_buffer.sv
// ----------------------------------------------------------------------------
// nx_ser_buffer
// Two-entry FIFO of {last, data} entries. Push and pop may coincide.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_push           : write i_push_entry at the tail (ignored when full)
//   i_pop            : drop the head entry (ignored when empty)
//   o_full, o_empty  : current occupancy flags
//   o_head           : current head entry
//   o_full_next      : occupancy flag after this cycle's push/pop
//   o_empty_next     : occupancy flag after this cycle's push/pop
//   o_head_next      : head entry after this cycle's push/pop
// ----------------------------------------------------------------------------
module nx_ser_buffer #(
    parameter int WIDTH = 129
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_entry,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full_next,
    output logic             o_empty_next,
    output logic [WIDTH-1:0] o_head_next
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q == 2'd2);
    assign o_empty = (count_q == 2'd0);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push_ok) begin
            if (wr_ptr_q) entry1_d = i_push_entry;
            else          entry0_d = i_push_entry;
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    assign o_head       = rd_ptr_q ? entry1_q : entry0_q;
    // Look-ahead head lets the serialiser register chunk 0 of a freshly
    // pushed response in the same cycle it is written.
    assign o_head_next  = rd_ptr_d ? entry1_d : entry0_d;
    assign o_full_next  = (count_d == 2'd2);
    assign o_empty_next = (count_d == 2'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nx_ctrl_serialiser.sv
// ----------------------------------------------------------------------------
// nx_ctrl_serialiser
// Accepts wide control responses and emits each as CHUNKS narrow host stream
// words, least-significant chunk first, through a two-entry buffer so that
// back-to-back responses stream without bubbles.
//   i_clk, i_rst             : clock, synchronous active-high reset
//   i_resp_data/last/valid   : response input, o_resp_ready handshake
//   o_host_data/last/valid   : host stream output, i_host_ready handshake
//   o_idle                   : buffer empty and no word pending
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   SER_EMPTY  | buffer empty, o_host_valid low
//   SER_STREAM | emitting chunk idx_q of the buffer head entry
// ----------------------------------------------------------------------------
module nx_ctrl_serialiser
    import NXConstants::*;
#(
    parameter int RESP_WIDTH   = $bits(control_response_t),
    parameter int STREAM_WIDTH = HOST_STREAM_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [RESP_WIDTH-1:0]   i_resp_data,
    input  logic                    i_resp_last,
    input  logic                    i_resp_valid,
    output logic                    o_resp_ready,
    output logic [STREAM_WIDTH-1:0] o_host_data,
    output logic                    o_host_last,
    output logic                    o_host_valid,
    input  logic                    i_host_ready,
    output logic                    o_idle
);

    localparam int CHUNKS = RESP_WIDTH / STREAM_WIDTH;
    localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    ser_state_t              state_q,      state_d;
    logic [IW-1:0]           idx_q,        idx_d;
    logic [STREAM_WIDTH-1:0] host_data_q,  host_data_d;
    logic                    host_last_q,  host_last_d;
    logic                    resp_ready_q, resp_ready_d;

    logic                  buf_push;
    logic                  buf_pop;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  buf_full_next;
    logic                  buf_empty_next;
    logic [RESP_WIDTH:0]   buf_head;
    logic [RESP_WIDTH:0]   buf_head_next;
    logic [RESP_WIDTH:0]   sel_head;
    logic                  host_fire;
    logic                  at_last_chunk;

    assign o_host_valid  = (state_q == SER_STREAM);
    assign host_fire     = o_host_valid && i_host_ready;
    assign at_last_chunk = (idx_q == LAST_IDX);
    assign buf_push      = i_resp_valid && resp_ready_q && !buf_full;
    assign buf_pop       = host_fire && at_last_chunk;

    nx_ser_buffer #(
        .WIDTH (RESP_WIDTH + 1)
    ) u_buffer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (buf_push),
        .i_push_entry ({i_resp_last, i_resp_data}),
        .i_pop        (buf_pop),
        .o_full       (buf_full),
        .o_empty      (buf_empty),
        .o_head       (buf_head),
        .o_full_next  (buf_full_next),
        .o_empty_next (buf_empty_next),
        .o_head_next  (buf_head_next)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        host_data_d  = '0;
        host_last_d  = 1'b0;
        resp_ready_d = !buf_full_next;

        if (host_fire) begin
            idx_d = at_last_chunk ? '0 : idx_q + 1'b1;
        end

        state_d = buf_empty_next ? SER_EMPTY : SER_STREAM;

        // The head only changes on a pop or when the buffer was empty; in
        // every other cycle, including stalls, the current head is reused so
        // data and last stay put.
        sel_head = (buf_pop || buf_empty) ? buf_head_next : buf_head;

        if (!buf_empty_next) begin
            host_data_d = sel_head[idx_d*STREAM_WIDTH +: STREAM_WIDTH];
            host_last_d = sel_head[RESP_WIDTH] && (idx_d == LAST_IDX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= SER_EMPTY;
            idx_q        <= '0;
            host_data_q  <= '0;
            host_last_q  <= 1'b0;
            resp_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            host_data_q  <= host_data_d;
            host_last_q  <= host_last_d;
            resp_ready_q <= resp_ready_d;
        end
    end

    assign o_host_data  = host_data_q;
    assign o_host_last  = host_last_q;
    assign o_resp_ready = resp_ready_q;
    assign o_idle       = buf_empty && !o_host_valid;

endmodule

// File: tb/tb_nx_ctrl_serialiser.sv
module tb_nx_ctrl_serialiser;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [127:0] i_resp_data;
    logic         i_resp_last;
    logic         i_resp_valid;
    logic         o_resp_ready;
    logic [31:0]  o_host_data;
    logic         o_host_last;
    logic         o_host_valid;
    logic         i_host_ready;
    logic         o_idle;

    int n_checks = 0;
    int n_errors = 0;

    logic        bp_ready [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int          bp_chunk [6] = '{1, 1, 1, 2, 3, -1};
    logic [31:0] single_words [4] = '{32'hBBBBAAAA, 32'hDDDDCCCC, 32'h22221111, 32'h44443333};

    always #5 i_clk = ~i_clk;

    nx_ctrl_serialiser dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_resp_data  (i_resp_data),
        .i_resp_last  (i_resp_last),
        .i_resp_valid (i_resp_valid),
        .o_resp_ready (o_resp_ready),
        .o_host_data  (o_host_data),
        .o_host_last  (o_host_last),
        .o_host_valid (o_host_valid),
        .i_host_ready (i_host_ready),
        .o_idle       (o_idle)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] data, input logic last);
        chk({tag, ".valid"}, 64'(o_host_valid), 64'd1);
        chk({tag, ".data"},  64'(o_host_data),  64'(data));
        chk({tag, ".last"},  64'(o_host_last),  64'(last));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".valid"}, 64'(o_host_valid), 64'd0);
        chk({tag, ".last"},  64'(o_host_last),  64'd0);
        chk({tag, ".idle"},  64'(o_idle),       64'd1);
    endtask

    function automatic logic [31:0] word(input int k, input int j);
        return 32'hC0DE0000 | 32'(k << 8) | 32'(j);
    endfunction

    function automatic logic [127:0] resp(input int k);
        return {word(k, 3), word(k, 2), word(k, 1), word(k, 0)};
    endfunction

    initial begin
        i_rst        = 1'b1;
        i_resp_data  = '0;
        i_resp_last  = 1'b0;
        i_resp_valid = 1'b0;
        i_host_ready = 1'b1;
        step();
        step();

        // reset state
        chk_quiet("reset");
        chk("reset.ready", 64'(o_resp_ready), 64'd1);
        chk("reset.data",  64'(o_host_data),  64'd0);
        i_rst = 1'b0;
        step();

        // single response, host always ready
        i_resp_data  = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
        i_resp_last  = 1'b1;
        i_resp_valid = 1'b1;
        chk("single.ready", 64'(o_resp_ready), 64'd1);
        step();
        i_resp_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk_word($sformatf("single.w%0d", j), single_words[j], j == 3);
            step();
        end
        chk_quiet("single.end");

        // back-to-back: three responses offered every 4 cycles
        for (int c = 0; c <= 12; c++) begin
            if (c < 12 && c % 4 == 0) begin
                i_resp_valid = 1'b1;
                i_resp_data  = resp(c / 4);
                i_resp_last  = (c / 4 == 2);
                chk($sformatf("b2b.ready%0d", c), 64'(o_resp_ready), 64'd1);
            end else begin
                i_resp_valid = 1'b0;
            end
            step();
            if (c < 12) begin
                chk_word($sformatf("b2b.w%0d", c), word(c / 4, c % 4), c == 11);
            end else begin
                chk_quiet("b2b.end");
            end
            if (c == 4 || c == 8) begin
                chk($sformatf("b2b.push_pop_ready%0d", c), 64'(o_resp_ready), 64'd1);
            end
        end
        i_resp_valid = 1'b0;

        // backpressure: host ready 1,0,0,1 during a response
        i_resp_data  = resp(5);
        i_resp_last  = 1'b1;
        i_resp_valid = 1'b1;
        i_host_ready = 1'b1;
        step();
        i_resp_valid = 1'b0;
        chk_word("bp.w0", word(5, 0), 1'b0);
        for (int i = 0; i < 6; i++) begin
            i_host_ready = bp_ready[i];
            step();
            if (bp_chunk[i] < 0) chk_quiet("bp.end");
            else chk_word($sformatf("bp.s%0d", i), word(5, bp_chunk[i]), bp_chunk[i] == 3);
        end

        // full buffer: host ready low, three responses offered
        i_host_ready = 1'b0;
        i_resp_data  = resp(6);
        i_resp_last  = 1'b1;
        i_resp_valid = 1'b1;
        step();
        chk("full.ready_after1", 64'(o_resp_ready), 64'd1);
        i_resp_data  = resp(7);
        i_resp_last  = 1'b0;
        step();
        chk("full.ready_after2", 64'(o_resp_ready), 64'd0);
        chk_word("full.stall0", word(6, 0), 1'b0);
        i_resp_data  = resp(8);
        i_resp_last  = 1'b1;
        step();
        step();
        chk("full.ready_held", 64'(o_resp_ready), 64'd0);
        chk_word("full.stall2", word(6, 0), 1'b0);
        i_host_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk_word($sformatf("full.r1w%0d", j), word(6, j), j == 3);
            chk($sformatf("full.ready_r1w%0d", j), 64'(o_resp_ready), 64'd0);
            step();
        end
        chk("full.ready_rise", 64'(o_resp_ready), 64'd1);
        chk_word("full.r2w0", word(7, 0), 1'b0);
        step();
        i_resp_valid = 1'b0;
        chk("full.ready_after3", 64'(o_resp_ready), 64'd0);
        for (int k = 0; k < 7; k++) begin
            if (k < 3) chk_word($sformatf("full.r2w%0d", k + 1), word(7, k + 1), 1'b0);
            else       chk_word($sformatf("full.r3w%0d", k - 3), word(8, k - 3), k == 6);
            step();
        end
        chk_quiet("full.end");

        // reset mid-packet after 2 of 4 words
        i_resp_data  = resp(9);
        i_resp_last  = 1'b1;
        i_resp_valid = 1'b1;
        step();
        i_resp_valid = 1'b0;
        chk_word("rst.w0", word(9, 0), 1'b0);
        step();
        chk_word("rst.w1", word(9, 1), 1'b0);
        step();
        chk_word("rst.w2", word(9, 2), 1'b0);
        i_rst = 1'b1;
        step();
        chk_quiet("rst.mid");
        chk("rst.ready", 64'(o_resp_ready), 64'd1);
        chk("rst.data",  64'(o_host_data),  64'd0);
        i_rst        = 1'b0;
        i_resp_data  = resp(10);
        i_resp_last  = 1'b0;
        i_resp_valid = 1'b1;
        step();
        i_resp_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk_word($sformatf("rst.new_w%0d", j), word(10, j), 1'b0);
            step();
        end
        chk_quiet("rst.end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
